// File: rtl/sprite_motion_ctrl_if.sv
// Control and position bundle between the sprite motion controller and
// the rest of the VGA pipeline (buttons, legal-move checker, sprite ROM).
interface sprite_motion_ctrl_if #(
  parameter int POS_W = 10
);
  logic             move_tick;
  logic             freeze;
  logic             up;
  logic             down;
  logic             left;
  logic             right;
  logic             leg_u;
  logic             leg_d;
  logic             leg_l;
  logic             leg_r;
  logic [POS_W-1:0] pm_xpos;
  logic [POS_W-1:0] pm_ypos;
  logic [1:0]       cur_dir;
  logic             facing_left;
  logic             moving;
  logic             moved;

  modport master (
    output move_tick, freeze, up, down, left, right,
    output leg_u, leg_d, leg_l, leg_r,
    input  pm_xpos, pm_ypos, cur_dir, facing_left, moving, moved
  );

  modport slave (
    input  move_tick, freeze, up, down, left, right,
    input  leg_u, leg_d, leg_l, leg_r,
    output pm_xpos, pm_ypos, cur_dir, facing_left, moving, moved
  );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Tile-based movement controller for one maze sprite: buffered turn requests,
// continuous motion on move_tick, optional horizontal tunnel wrap.
module sprite_motion_ctrl #(
  parameter int POS_W   = 10,
  parameter int STEP    = 2,
  parameter int TILE    = 8,
  parameter int X_MIN   = 150,
  parameter int X_MAX   = 630,
  parameter int Y_MIN   = 34,
  parameter int Y_MAX   = 514,
  parameter int X_INIT  = 358,
  parameter int Y_INIT  = 402,
  parameter int WRAP_EN = 1
) (
  input logic                 clk,
  input logic                 rst,
  sprite_motion_ctrl_if.slave bus_if
);
  localparam logic [1:0] DIR_R = 2'd0;
  localparam logic [1:0] DIR_L = 2'd1;
  localparam logic [1:0] DIR_U = 2'd2;
  localparam logic [1:0] DIR_D = 2'd3;

  localparam logic [POS_W-1:0] XMIN_P = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] XMAX_P = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] YMIN_P = POS_W'(Y_MIN);
  localparam logic [POS_W-1:0] YMAX_P = POS_W'(Y_MAX);
  localparam logic [POS_W-1:0] STEP_P = POS_W'(STEP);
  localparam logic [POS_W-1:0] TMSK_P = POS_W'(TILE - 1);
  // One extra bit so boundary sums cannot overflow the position width.
  localparam logic [POS_W:0]   XMIN_W = (POS_W+1)'(X_MIN);
  localparam logic [POS_W:0]   XMAX_W = (POS_W+1)'(X_MAX);
  localparam logic [POS_W:0]   YMIN_W = (POS_W+1)'(Y_MIN);
  localparam logic [POS_W:0]   YMAX_W = (POS_W+1)'(Y_MAX);
  localparam logic [POS_W:0]   STEP_W = (POS_W+1)'(STEP);

  typedef enum logic {ST_STOP = 1'b0, ST_MOVE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]       cur_dir_q, cur_dir_d, pend_dir_q, pend_dir_d;
  logic             pend_valid_q, pend_valid_d;
  logic             facing_q, facing_d;
  logic             moved_q, moved_d;

  logic             tick, aligned, adopt, cont, blocked, any_btn;
  logic [1:0]       btn_dir, step_dir;
  logic [3:0]       leg_vec;
  logic [POS_W-1:0] x_off, y_off;
  logic [POS_W:0]   x_wide, y_wide;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_STOP;
      x_q          <= POS_W'(X_INIT);
      y_q          <= POS_W'(Y_INIT);
      cur_dir_q    <= DIR_R;
      pend_dir_q   <= DIR_R;
      pend_valid_q <= 1'b0;
      facing_q     <= 1'b0;
      moved_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cur_dir_q    <= cur_dir_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      facing_q     <= facing_d;
      moved_q      <= moved_d;
    end
  end

  always_comb begin
    any_btn = bus_if.right | bus_if.left | bus_if.up | bus_if.down;
    btn_dir = bus_if.right ? DIR_R : bus_if.left ? DIR_L : bus_if.up ? DIR_U : DIR_D;
    leg_vec = {bus_if.leg_d, bus_if.leg_u, bus_if.leg_l, bus_if.leg_r};
    x_off   = x_q - XMIN_P;
    y_off   = y_q - YMIN_P;
    aligned = ((x_off & TMSK_P) == '0) && ((y_off & TMSK_P) == '0);
    tick    = bus_if.move_tick & ~bus_if.freeze;
    // Direction codes pair up so flipping bit 0 gives the reverse direction.
    adopt   = tick && pend_valid_q && leg_vec[pend_dir_q] &&
              (aligned || (pend_dir_q == (cur_dir_q ^ 2'b01)));
    cont    = tick && !adopt && (state_q == ST_MOVE) && leg_vec[cur_dir_q];
    blocked = tick && !adopt && (state_q == ST_MOVE) && !leg_vec[cur_dir_q];
    step_dir = adopt ? pend_dir_q : cur_dir_q;
    x_wide  = {1'b0, x_q};
    y_wide  = {1'b0, y_q};

    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cur_dir_d    = cur_dir_q;
    facing_d     = facing_q;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;

    if (adopt || cont) begin
      if (adopt) begin
        cur_dir_d = pend_dir_q;
        state_d   = ST_MOVE;
        if (pend_dir_q == DIR_L) facing_d = 1'b1;
        if (pend_dir_q == DIR_R) facing_d = 1'b0;
      end
      case (step_dir)
        DIR_R: begin
          if (x_wide + STEP_W > XMAX_W) begin
            if (WRAP_EN != 0) x_d = XMIN_P;
            else begin
              x_d     = XMAX_P;
              state_d = ST_STOP;
            end
          end else x_d = x_q + STEP_P;
        end
        DIR_L: begin
          if (x_wide < XMIN_W + STEP_W) begin
            if (WRAP_EN != 0) x_d = XMAX_P;
            else begin
              x_d     = XMIN_P;
              state_d = ST_STOP;
            end
          end else x_d = x_q - STEP_P;
        end
        DIR_U: begin
          if (y_wide < YMIN_W + STEP_W) begin
            y_d     = YMIN_P;
            state_d = ST_STOP;
          end else y_d = y_q - STEP_P;
        end
        default: begin
          if (y_wide + STEP_W > YMAX_W) begin
            y_d     = YMAX_P;
            state_d = ST_STOP;
          end else y_d = y_q + STEP_P;
        end
      endcase
    end else if (blocked) begin
      state_d = ST_STOP;
    end

    // A press in the consuming cycle re-arms the request.
    if (any_btn) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = btn_dir;
    end else if (adopt) begin
      pend_valid_d = 1'b0;
    end

    moved_d = (x_d != x_q) || (y_d != y_q);
  end

  always_comb begin
    bus_if.pm_xpos     = x_q;
    bus_if.pm_ypos     = y_q;
    bus_if.cur_dir     = cur_dir_q;
    bus_if.facing_left = facing_q;
    bus_if.moving      = (state_q == ST_MOVE);
    bus_if.moved       = moved_q;
  end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench: two controllers (wrap on / wrap off) share stimulus; the
// expected outputs of each are queued and checked by an independent monitor.
module tb_sprite_motion_ctrl;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] dir;
    logic       mv;
    logic       fl;
    logic       md;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic move_tick = 1'b0, freeze = 1'b0;
  logic b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0;
  logic l_u = 1'b1, l_d = 1'b1, l_l = 1'b1, l_r = 1'b1;

  int   checks = 0;
  int   failures = 0;
  exp_t qw[$];
  exp_t qn[$];
  exp_t mw, mn, gw, gn;

  always #5 clk = ~clk;

  sprite_motion_ctrl_if #(.POS_W(10)) if_w ();
  sprite_motion_ctrl_if #(.POS_W(10)) if_n ();

  assign if_w.move_tick = move_tick;  assign if_n.move_tick = move_tick;
  assign if_w.freeze    = freeze;     assign if_n.freeze    = freeze;
  assign if_w.up        = b_up;       assign if_n.up        = b_up;
  assign if_w.down      = b_down;     assign if_n.down      = b_down;
  assign if_w.left      = b_left;     assign if_n.left      = b_left;
  assign if_w.right     = b_right;    assign if_n.right     = b_right;
  assign if_w.leg_u     = l_u;        assign if_n.leg_u     = l_u;
  assign if_w.leg_d     = l_d;        assign if_n.leg_d     = l_d;
  assign if_w.leg_l     = l_l;        assign if_n.leg_l     = l_l;
  assign if_w.leg_r     = l_r;        assign if_n.leg_r     = l_r;

  sprite_motion_ctrl #(.WRAP_EN(1)) dut_w (.clk(clk), .rst(rst), .bus_if(if_w.slave));
  sprite_motion_ctrl #(.WRAP_EN(0)) dut_n (.clk(clk), .rst(rst), .bus_if(if_n.slave));

  function automatic exp_t mk(input int x, input int y, input int d,
                              input bit mv, input bit fl, input bit md);
    exp_t e;
    e.x = 10'(x); e.y = 10'(y); e.dir = 2'(d); e.mv = mv; e.fl = fl; e.md = md;
    return e;
  endfunction

  task automatic cmp(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s #%0d: got x=%0d y=%0d dir=%0d mv=%0b fl=%0b md=%0b, want x=%0d y=%0d dir=%0d mv=%0b fl=%0b md=%0b",
               name, checks, got.x, got.y, got.dir, got.mv, got.fl, got.md,
               want.x, want.y, want.dir, want.mv, want.fl, want.md);
    end else begin
      $display("ok   %s #%0d: x=%0d y=%0d dir=%0d mv=%0b fl=%0b md=%0b",
               name, checks, got.x, got.y, got.dir, got.mv, got.fl, got.md);
    end
  endtask

  always @(negedge clk) begin
    if (qw.size() > 0 && qn.size() > 0) begin
      mw = qw.pop_front();
      mn = qn.pop_front();
      gw = {if_w.pm_xpos, if_w.pm_ypos, if_w.cur_dir, if_w.moving, if_w.facing_left, if_w.moved};
      gn = {if_n.pm_xpos, if_n.pm_ypos, if_n.cur_dir, if_n.moving, if_n.facing_left, if_n.moved};
      cmp("wrap", gw, mw);
      cmp("nowrap", gn, mn);
    end
  end

  task automatic tick2(input exp_t ew, input exp_t en);
    @(posedge clk); #1 move_tick = 1'b1;
    @(posedge clk); #1 move_tick = 1'b0;
    qw.push_back(ew);
    qn.push_back(en);
  endtask

  task automatic tick(input exp_t e);
    tick2(e, e);
  endtask

  task automatic check_now(input exp_t e);
    @(posedge clk); #1;
    qw.push_back(e);
    qn.push_back(e);
  endtask

  task automatic press(input int d);
    @(posedge clk); #1;
    b_right = (d == 0); b_left = (d == 1); b_up = (d == 2); b_down = (d == 3);
    @(posedge clk); #1;
    b_right = 1'b0; b_left = 1'b0; b_up = 1'b0; b_down = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_now(mk(358, 402, 0, 0, 0, 0));

    // Start right from rest, then continuous motion and moved falling.
    press(0);
    tick(mk(360, 402, 0, 1, 0, 1));
    tick(mk(362, 402, 0, 1, 0, 1));
    tick(mk(364, 402, 0, 1, 0, 1));
    check_now(mk(364, 402, 0, 1, 0, 0));

    // Pre-turn up waits for tile alignment at x=366.
    do_reset();
    press(0);
    tick(mk(360, 402, 0, 1, 0, 1));
    tick(mk(362, 402, 0, 1, 0, 1));
    press(2);
    tick(mk(364, 402, 0, 1, 0, 1));
    tick(mk(366, 402, 0, 1, 0, 1));
    tick(mk(366, 400, 2, 1, 0, 1));
    tick(mk(366, 398, 2, 1, 0, 1));

    // Reverse is immediate; freeze suppresses a tick.
    do_reset();
    press(0);
    tick(mk(360, 402, 0, 1, 0, 1));
    tick(mk(362, 402, 0, 1, 0, 1));
    press(1);
    tick(mk(360, 402, 1, 1, 1, 1));
    freeze = 1'b1;
    tick(mk(360, 402, 1, 1, 1, 0));
    freeze = 1'b0;
    tick(mk(358, 402, 1, 1, 1, 1));

    // Blocked stop, then a request that waits for its legal flag.
    do_reset();
    press(0);
    tick(mk(360, 402, 0, 1, 0, 1));
    tick(mk(362, 402, 0, 1, 0, 1));
    tick(mk(364, 402, 0, 1, 0, 1));
    tick(mk(366, 402, 0, 1, 0, 1));
    l_r = 1'b0;
    tick(mk(366, 402, 0, 0, 0, 0));
    l_d = 1'b0;
    press(3);
    for (int k = 0; k < 5; k++) tick(mk(366, 402, 0, 0, 0, 0));
    l_d = 1'b1;
    tick(mk(366, 404, 3, 1, 0, 1));
    l_r = 1'b1;

    // Run to the right edge: wrap vs clamp, then asynchronous reset mid-move.
    do_reset();
    press(0);
    for (int k = 1; k <= 136; k++) tick(mk(358 + 2 * k, 402, 0, 1, 0, 1));
    tick2(mk(150, 402, 0, 1, 0, 1), mk(630, 402, 0, 0, 0, 0));
    tick2(mk(152, 402, 0, 1, 0, 1), mk(630, 402, 0, 0, 0, 0));
    @(posedge clk); #1 rst = 1'b1;
    qw.push_back(mk(358, 402, 0, 0, 0, 0));
    qn.push_back(mk(358, 402, 0, 0, 0, 0));
    @(posedge clk); #1 rst = 1'b0;
    check_now(mk(358, 402, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    checks++;
    if (qw.size() != 0 || qn.size() != 0) begin
      failures++;
      $display("FAIL drain: queued=%0d/%0d, want 0/0", qw.size(), qn.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Parametrised movement controller for one maze sprite (Pac-Man or a ghost) in the VGA pipeline. It replaces the slow-clock, button-held movement scheme with the following:
- a single-clock design advanced by a move_tick enable;
- buffered (pre-turn) direction requests, taken up only at tile alignment;
- continuous motion while the path is legal;
- optional horizontal tunnel wrap.

Position outputs feed the sprite ROM address/fill logic. The leg_* inputs come from the legal-move checker, evaluated at the current position.

Parameters:
POS_W, 10, width of position registers and ports
STEP, 2, pixels moved per move_tick; must divide TILE
TILE, 8, maze tile pitch in pixels; power of two
X_MIN, 150, leftmost legal x (hCount units)
X_MAX, 630, rightmost legal x
Y_MIN, 34, topmost legal y (vCount units)
Y_MAX, 514, bottommost legal y
X_INIT, 358, reset x
Y_INIT, 402, reset y
WRAP_EN, 1, 1 = horizontal tunnel wrap; 0 = clamp and stop

Ports:
clk  in  1  system clock (single clock domain)
rst  in  1  asynchronous, active-high reset
move_tick  in  1  one-clk movement enable pulse
freeze  in  1  1 = suppress movement on ticks
up, down, left, right  in  1 each  direction buttons, level
leg_u, leg_d, leg_l, leg_r  in  1 each  legal-move flags for current (pm_xpos, pm_ypos)
pm_xpos  out  POS_W  sprite x
pm_ypos  out  POS_W  sprite y
cur_dir  out  2  0=right, 1=left, 2=up, 3=down
facing_left  out  1  sprite mirror select
moving  out  1  1 in MOVE state
moved  out  1  one-clk pulse, position changed this cycle

Behaviour:
- Reset (async, rst=1): pm_xpos=X_INIT, pm_ypos=Y_INIT, cur_dir=0, facing_left=0, state=STOP, moving=0, moved=0, pend_valid=0, pend_dir=0.
- Request capture (every clk, independent of tick and freeze):
  - If any button is high, pend_dir <= priority-encoded direction (right > left > up > down) and pend_valid <= 1.
  - A newer press overwrites the pending direction.
  - A button press in the same clk that a pending request is consumed re-arms pend_valid.
- Alignment: aligned = ((pm_xpos-X_MIN) mod TILE == 0) and ((pm_ypos-Y_MIN) mod TILE == 0).
- Reverse: the opposite of cur_dir (right/left, up/down).
- State machine (STOP, MOVE). Evaluated only on move_tick=1 and freeze=0, in priority order:
  1. Adopt request: condition is pend_valid and leg[pend_dir] and (aligned, or pend_dir is reverse, or state=STOP with aligned). Action: cur_dir <= pend_dir, pend_valid <= 0, state <= MOVE, and one STEP is taken in pend_dir in the same tick.
  2. Continue: condition is state=MOVE and leg[cur_dir]. Action: one STEP in cur_dir.
  3. Blocked: condition is state=MOVE and !leg[cur_dir]. Action: position unchanged, state <= STOP. cur_dir is retained.
  4. Otherwise: hold.
  - A request that cannot be adopted stays pending indefinitely.
- Arithmetic: x/y are unsigned POS_W; next = pos ± STEP.
  - Right, x+STEP > X_MAX: WRAP_EN=1 → x <= X_MIN; WRAP_EN=0 → x <= X_MAX and state <= STOP.
  - Left, x < X_MIN+STEP: WRAP_EN=1 → x <= X_MAX; WRAP_EN=0 → x <= X_MIN and state <= STOP.
  - Vertical moves always clamp to Y_MIN/Y_MAX and enter STOP at a boundary.
- facing_left: set to 1 when cur_dir becomes left, cleared when it becomes right, unchanged for up/down.
- moved: registered; equals 1 in the clk after a tick in which pm_xpos or pm_ypos changed, 0 otherwise.
- moving: equals (state==MOVE).
- Latency: position updates on the clk edge where move_tick=1.
- freeze=1 with move_tick=1: no movement and no state change; requests are still captured.
- Reset mid-move: all state returns to reset values immediately; a pending request is discarded.

Test Plan:
- Reset → pm_xpos=358, pm_ypos=402, cur_dir=0, moving=0, facing_left=0, moved=0.
- right pulsed 1 clk with leg_r=1, then 3 ticks, button released → x=360, 362, 364; moving=1; moved pulses after each tick.
- Moving right at x=362, up pressed with leg_u=1 → ticks give x=364, 366 with y=402 (not aligned); the next tick at aligned x=366 gives y=400, cur_dir=2, pend_valid=0.
- Moving right at x=362, left pressed with leg_l=1 → next tick gives x=360, facing_left=1, no alignment wait; freeze=1 during a tick → no change.
- Moving right, leg_r=0 on a tick → position held, moving=0. Then down requested with leg_d=0 → stays pending across 5 ticks. Then leg_d=1 → y=404 on the next tick.
- WRAP_EN=1, moving right at x=630 → next tick x=150. WRAP_EN=0 → x=630, moving=0. Assert rst mid-move → outputs return to reset values asynchronously.
